m_bus_unpack: RTL and testbench
===============================

// Module: m_bus_unpack
// PURPOSE
//  Word-to-slice unpacker: accepts one NUM_SLICES*SLICE_W-bit word and emits its
//  SLICE_W-bit slices one per cycle, over a valid/ready stream.
//  Inverse of the bus concatenation/replication packing used elsewhere in the design.
//  Sits between a wide-bus producer and a narrow consumer.
// PARAMETERS
//  SLICE_W     4   width of one output slice (bits)
//  NUM_SLICES  4   slices per input word (>=2); WORD_W = SLICE_W*NUM_SLICES
//  IDX_W       $clog2(NUM_SLICES)   slice index width (derived; do not override)
// PORTS
//  clk        in   1         single clock, rising edge
//  rst_n      in   1         synchronous reset, active-low
//  in_valid   in   1         input word valid
//  in_ready   out  1         unpacker can take a word this cycle
//  in_data    in   WORD_W    input word
//  out_valid  out  1         out_data holds a valid slice
//  out_ready  in   1         consumer takes the slice this cycle
//  out_data   out  SLICE_W   current slice
//  out_idx    out  IDX_W     index of the current slice in its word (emission order)
//  out_last   out  1         current slice is the final slice of its word
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, idx=0, holding reg=0; out_valid=0,
//    out_data=0, out_idx=0, out_last=0, in_ready=1. Reset mid-word drops the word silently.
//  - Input transfer: in_valid & in_ready at posedge. Output transfer: out_valid & out_ready.
//  - States: IDLE (no word held) and SEND (word held, slice idx presented).
//    IDLE -> SEND on input transfer; word captured, idx=0.
//    SEND, output transfer, idx<NUM_SLICES-1 -> idx+1, stay SEND.
//    SEND, output transfer, idx=NUM_SLICES-1: on simultaneous input transfer reload
//    the word, set idx=0, stay SEND; otherwise go IDLE.
//  - in_ready = (state==IDLE) | (out_last & out_ready) (combinational on out_ready).
//    Back-to-back words stream with no bubble: NUM_SLICES cycles per word.
//  - Latency: the first slice is valid the cycle after the input transfer.
//  - out_valid = (state==SEND). out_data, out_idx and out_last are registered state or
//    a mux of registered state, and stay stable while out_valid & ~out_ready.
//  - out_last = out_valid & (idx==NUM_SLICES-1). out_data=0 while out_valid=0.
//  - idx never wraps past NUM_SLICES-1. A non-power-of-2 NUM_SLICES leaves idx codes unused.
//  - in_data is ignored unless an input transfer occurs; no X propagates to outputs.
// CONFIGURATION
//  - Macro BUS_UNPACK_MSB_FIRST_EN defined: slice idx = in_data[WORD_W-1-idx*SLICE_W -: SLICE_W].
//    This is MSB first and matches {a,b,...} concatenation order.
//  - Not defined (default): slice idx = in_data[idx*SLICE_W +: SLICE_W] (LSB first).
//  - out_idx always counts 0..NUM_SLICES-1 in emission order, with or without the macro.
// STRUCTURE
//  - Package m_bus_pkg holds the state typedef (IDLE/SEND) and a clog2-based
//    IDX_W helper function. Other bus blocks share it.
//  - One sub-module, m_slice_sel: purely combinational; selects slice idx from the held
//    word. It contains the only BUS_UNPACK_MSB_FIRST_EN conditional. The FSM, counter
//    and holding register stay in m_bus_unpack.
// TESTING (defaults SLICE_W=4, NUM_SLICES=4)
//  1 Reset: hold rst_n=0 2 cycles with in_valid=1 -> out_valid=0, in_ready=1,
//    out_data=0, out_idx=0.
//  2 Single word 16'hABCD, out_ready=1 -> out_data D,C,B,A on cycles 1..4 after accept,
//    out_last only with A. With BUS_UNPACK_MSB_FIRST_EN: A,B,C,D, last with D.
//  3 Back-to-back 16'h1234 then 16'h5678, in_valid held -> 8 consecutive valid slices,
//    4,3,2,1,8,7,6,5. in_ready is high only in the last-slice cycles.
//  4 Backpressure: out_ready low 3 cycles at idx=1 -> out_data/out_idx/out_last held
//    stable, in_ready=0. Stream resumes without loss or duplication.
//  5 Reset mid-word at idx=2 -> next cycle IDLE, out_valid=0. A new word 16'hF00F
//    emits F,0,0,F from idx 0.
//  6 Replicated word {4{4'b1101}} -> four slices 4'hD. in_data toggling while SEND
//    does not alter the emitted slices.

Source files
------------

// File: rtl/m_bus_pkg.sv
// m_bus_pkg: types and helpers shared by the bus pack/unpack blocks.
//   - state_t    : two-state sequencing for word-to-slice unpacking
//   - idx_width(): width of a slice index for a given slice count (min 1 bit)

package m_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // A single-slice bus would still need a 1-bit index to keep ports legal.
    function automatic int idx_width(input int num_slices);
        if (num_slices <= 1) begin
            return 1;
        end
        return $clog2(num_slices);
    endfunction

endpackage

// File: rtl/m_slice_sel.sv
// m_slice_sel: combinational slice selector for the unpacker.
// Picks slice number idx out of a held word.
// Config macro: BUS_UNPACK_MSB_FIRST_EN
//   defined     -> slice 0 is the top SLICE_W bits ({a,b,...} concatenation order)
//   not defined -> slice 0 is the bottom SLICE_W bits (LSB first)
// idx codes at or beyond NUM_SLICES select zero.

module m_slice_sel #(
    parameter int SLICE_W    = 4,
    parameter int NUM_SLICES = 4,
    parameter int IDX_W      = 2
) (
    input  logic [SLICE_W*NUM_SLICES-1:0] word,
    input  logic [IDX_W-1:0]              idx,
    output logic [SLICE_W-1:0]            slice
);

    localparam int WORD_W = SLICE_W * NUM_SLICES;

    // Compare against each legal index so no out-of-range part-select is ever formed.
    always_comb begin
        slice = '0;
        for (int i = 0; i < NUM_SLICES; i++) begin
            if (idx == IDX_W'(i)) begin
`ifdef BUS_UNPACK_MSB_FIRST_EN
                slice = word[WORD_W-1-i*SLICE_W -: SLICE_W];
`else
                slice = word[i*SLICE_W +: SLICE_W];
`endif
            end
        end
    end

endmodule

// File: rtl/m_bus_unpack.sv
// m_bus_unpack: word-to-slice unpacker on a valid/ready stream.
// Takes one SLICE_W*NUM_SLICES-bit word and emits its slices one per cycle,
// tagging each with its emission index and flagging the final slice.
// Back-to-back words stream without a bubble: the next word is accepted in the
// same cycle the last slice of the current word is consumed.
// Config macro: BUS_UNPACK_MSB_FIRST_EN (slice ordering, handled in m_slice_sel).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no word held; in_ready=1, out_valid=0
// SEND  | word held, slice idx presented on out_data/out_idx/out_last

module m_bus_unpack
    import m_bus_pkg::*;
#(
    parameter int SLICE_W    = 4,
    parameter int NUM_SLICES = 4,
    parameter int IDX_W      = idx_width(NUM_SLICES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SLICE_W*NUM_SLICES-1:0] in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SLICE_W-1:0]            out_data,
    output logic [IDX_W-1:0]              out_idx,
    output logic                          out_last
);

    localparam int                WORD_W   = SLICE_W * NUM_SLICES;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_SLICES - 1);

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [WORD_W-1:0]   word;
    logic [SLICE_W-1:0]  sel_slice;
    logic                in_xfer;
    logic                out_xfer;
    logic                at_last;

    // Handshake qualifiers; in_ready looks through out_ready so a new word can
    // land on the cycle the final slice leaves.
    always_comb begin
        at_last   = (idx == IDX_LAST);
        out_valid = (state == SEND);
        out_last  = out_valid & at_last;
        in_ready  = (state == IDLE) | (out_last & out_ready);
        in_xfer   = in_valid & in_ready;
        out_xfer  = out_valid & out_ready;
    end

    // Sequencer, slice counter and holding register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            word  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_xfer) begin
                        word  <= in_data;
                        idx   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (out_xfer) begin
                        if (!at_last) begin
                            idx <= idx + IDX_W'(1);
                        end else if (in_xfer) begin
                            word <= in_data;
                            idx  <= '0;
                        end else begin
                            idx   <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    m_slice_sel #(
        .SLICE_W    (SLICE_W),
        .NUM_SLICES (NUM_SLICES),
        .IDX_W      (IDX_W)
    ) u_slice_sel (
        .word  (word),
        .idx   (idx),
        .slice (sel_slice)
    );

    // Present the selected slice only while valid; the held word may be stale in IDLE.
    always_comb begin
        out_data = out_valid ? sel_slice : '0;
        out_idx  = idx;
    end

endmodule

// File: tb/tb_m_bus_unpack.sv
// tb_m_bus_unpack: directed + random stimulus against a queue-based reference.
// The reference keeps the list of slices still owed by the current word; a word
// acceptance appends all of its slices, each output handshake removes the head.

module tb_m_bus_unpack;

    localparam int SW = 4;
    localparam int NS = 4;
    localparam int WW = SW * NS;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [SW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          out_last;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [SW-1:0] d;
        int            idx;
    } slice_t;

    slice_t q[$];

    m_bus_unpack #(
        .SLICE_W    (SW),
        .NUM_SLICES (NS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] slice_of(input logic [WW-1:0] w, input int i);
`ifdef BUS_UNPACK_MSB_FIRST_EN
        return SW'(w >> ((NS - 1 - i) * SW));
`else
        return SW'(w >> (i * SW));
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic cyc();
        logic ev, er, iacc, oacc;
        logic [WW-1:0] w;
        @(negedge clk);
        ev = (q.size() > 0);
        er = (q.size() == 0) || (q.size() == 1 && out_ready);
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_data", 32'(out_data), ev ? 32'(q[0].d) : 32'd0);
        chk("out_last", 32'(out_last), 32'(ev && q[0].idx == NS - 1));
        if (ev) chk("out_idx", 32'(out_idx), 32'(q[0].idx));
        iacc = in_valid & er;
        oacc = ev & out_ready;
        w    = in_data;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
        end else begin
            if (oacc) void'(q.pop_front());
            if (iacc) for (int i = 0; i < NS; i++) q.push_back('{slice_of(w, i), i});
        end
        #1;
    endtask

    initial begin
        // 1: reset held with in_valid high
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h5A5A;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        cyc();
        cyc();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        cyc();

        // 2: single word
        in_data   = 16'hABCD;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc();
`ifdef BUS_UNPACK_MSB_FIRST_EN
        chk("t2_first", 32'(out_data), 32'hA);
`else
        chk("t2_first", 32'(out_data), 32'hD);
`endif
        in_valid = 1'b0;
        repeat (5) cyc();

        // 3: back-to-back words with in_valid held
        in_valid = 1'b1;
        in_data  = 16'h1234;
        cyc();
        in_data = 16'h5678;
        repeat (4) cyc();
        in_valid = 1'b0;
        repeat (5) cyc();

        // 4: backpressure at idx 1
        in_data  = 16'h9C3E;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h7777;
        repeat (3) cyc();
        chk("t4_hold_idx", 32'(out_idx), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();

        // 5: reset mid-word at idx 2, then a fresh word
        in_data  = 16'h2468;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        repeat (2) cyc();
        chk("t5_idx2", 32'(out_idx), 32'd2);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        in_data  = 16'hF00F;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        repeat (5) cyc();

        // 6: replicated word, in_data toggling during SEND
        in_data  = {4{4'b1101}};
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        repeat (4) begin
            in_data = WW'($urandom);
            cyc();
        end
        cyc();

        // random traffic with rare resets
        for (int n = 0; n < 600; n++) begin
            rst_n     = ($urandom_range(0, 63) != 0);
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = WW'($urandom);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
